fios_job_scheduler: RTL and testbench

- Shares one FIOS Montgomery-multiplication engine between NREQ requesters.
- For each job it:
  - arbitrates round-robin,
  - steers the operand memory to the winning requester,
  - sequences operand load, FIOS start and result collection,
  - reports done or error back to the requester.
- Sits between the requester ports and the FIOS/memory pair. A watchdog recovers a hung engine.

---
 rtl/fios_job_scheduler.sv | 149 ++++++++++++++
 tb/tb_fios_job_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fios_job_scheduler.sv
// Round-robin job scheduler sharing one FIOS Montgomery engine and its operand
// memory between NREQ requesters, with result counting and a run watchdog.
module fios_job_scheduler #(
    parameter int s       = 16,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 2048
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic [NREQ-1:0]        req_i,
    output logic [NREQ-1:0]        grant_o,
    output logic [NREQ-1:0]        done_o,
    output logic [NREQ-1:0]        err_o,
    output logic                   load_o,
    input  logic                   load_done_i,
    output logic                   start_o,
    input  logic                   res_push_i,
    input  logic                   last_i,
    output logic                   fios_clear_o,
    output logic [$clog2(s+2)-1:0] res_count_o,
    output logic                   busy_o
);

    localparam int CW = $clog2(s + 2);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] RES_FULL = CW'(s + 1);

    typedef enum logic [3:0] {
        IDLE, ARB, LOAD, WAIT_LOAD, START, RUN, DRAIN, DONE, ABORT
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   win_q, win_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   wd_q, wd_d;

    logic [NREQ-1:0] req_rot;
    logic [IW:0]     cand;
    logic [IW-1:0]   pick;
    logic            pick_vld;
    logic [CW-1:0]   cnt_inc;
    logic [IW-1:0]   rr_next;

    // Rotate requests so bit 0 is the rr_ptr position; lowest set offset wins.
    always_comb begin
        req_rot  = NREQ'({req_i, req_i} >> rr_q);
        cand     = '0;
        pick_vld = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                cand     = {1'b0, rr_q} + (IW+1)'(i);
                pick_vld = 1'b1;
            end
        end
        if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
        pick = cand[IW-1:0];
    end

    assign cnt_inc = (res_push_i && cnt_q != RES_FULL) ? cnt_q + CW'(1) : cnt_q;
    assign rr_next = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        win_d        = win_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        wd_d         = wd_q;
        done_o       = '0;
        err_o        = '0;
        load_o       = 1'b0;
        start_o      = 1'b0;
        fios_clear_o = 1'b0;
        case (state_q)
            IDLE: if (|req_i) state_d = ARB;
            ARB: begin
                if (pick_vld) begin
                    win_d   = pick;
                    grant_d = NREQ'(1) << pick;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                load_o  = 1'b1;
                state_d = WAIT_LOAD;
            end
            WAIT_LOAD: if (load_done_i) state_d = START;
            START: begin
                start_o = 1'b1;
                cnt_d   = '0;
                wd_d    = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_inc;
                wd_d  = wd_q + WW'(1);
                // ABORT then lands exactly TIMEOUT cycles after start_o; timeout beats last_i.
                if (wd_q == WW'(TIMEOUT - 2)) state_d = ABORT;
                else if (last_i)              state_d = DRAIN;
            end
            DRAIN: begin
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == RES_FULL) ? DONE : ABORT;
            end
            DONE: begin
                done_o  = grant_q;
                grant_d = '0;
                rr_d    = rr_next;
                state_d = IDLE;
            end
            ABORT: begin
                err_o        = grant_q;
                fios_clear_o = 1'b1;
                grant_d      = '0;
                rr_d         = rr_next;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            win_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
        end
    end

    assign grant_o     = grant_q;
    assign res_count_o = cnt_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_fios_job_scheduler.sv
// Directed/randomized bench for fios_job_scheduler; job outcomes predicted from
// push counts, last/timeout position and a round-robin pointer model.
module tb_fios_job_scheduler;

    localparam int S   = 16;
    localparam int NR  = 2;
    localparam int TO  = 64;
    localparam int CW  = $clog2(S + 2);
    localparam int RES = S + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req_i;
    logic [NR-1:0] grant_o, done_o, err_o;
    logic          load_o, load_done_i, start_o;
    logic          res_push_i, last_i, fios_clear_o, busy_o;
    logic [CW-1:0] res_count_o;

    int checks   = 0;
    int failures = 0;
    int rr_m     = 0;
    int last_cnt = 0;

    fios_job_scheduler #(.s(S), .NREQ(NR), .TIMEOUT(TO)) dut (
        .clock_i(clk), .reset_i(rst_n), .req_i(req_i), .grant_o(grant_o),
        .done_o(done_o), .err_o(err_o), .load_o(load_o), .load_done_i(load_done_i),
        .start_o(start_o), .res_push_i(res_push_i), .last_i(last_i),
        .fios_clear_o(fios_clear_o), .res_count_o(res_count_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, grant_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_ctl"}, {load_o, start_o, fios_clear_o, busy_o}, 0);
        chk({tag, "_cnt"}, res_count_o, 0);
    endtask

    // Round-robin: first requester at or after rr_m, wrapping.
    function automatic int pick_m(input logic [NR-1:0] r);
        for (int i = 0; i < NR; i++) begin
            int k;
            k = (rr_m + i) % NR;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    // IDLE -> ARB -> LOAD -> WAIT_LOAD (ld_delay>=1 cycles) -> START.
    task automatic job_front(input logic [NR-1:0] req, input int ld_delay, output int w);
        req_i = req;
        tick();
        chk("arb_busy", busy_o, 1);
        chk("arb_grant", grant_o, 0);
        w = pick_m(req);
        tick();
        chk("load_grant", grant_o, 1 << w);
        chk("load_pulse", load_o, 1);
        for (int i = 0; i < ld_delay; i++) begin
            res_push_i = 1'($urandom);
            last_i     = 1'($urandom);
            tick();
            chk("wait_quiet", {load_o, start_o}, 0);
        end
        res_push_i  = 1'b0;
        last_i      = 1'b0;
        load_done_i = 1'b1;
        tick();
        load_done_i = 1'b0;
        chk("start_pulse", start_o, 1);
        chk("start_grant", grant_o, 1 << w);
    endtask

    // RUN phase: npush pushes with random gaps, last with the final one; optional
    // trailing push in DRAIN. use_last=0 never raises last (watchdog path).
    task automatic job_back(input int w, input int npush, input bit use_last, input bit trail,
                            input logic [NR-1:0] req_run, input logic [NR-1:0] req_end);
        int  cnt = 0, sent = 0;
        bit  drained = 0, p, l;
        bit  ok;
        int  exp_cnt;
        tick();
        for (int k = 1; k <= TO - 1; k++) begin
            p = (!use_last || sent < npush) && ($urandom_range(0, 3) != 0);
            l = use_last && ((p && sent + 1 == npush) || npush == 0);
            sent += int'(p);
            if (k == 2) req_i = req_run;
            res_push_i = p;
            last_i     = l;
            cnt       += int'(p);
            tick();
            if (k == TO - 1) break;
            if (l) begin
                drained = 1;
                break;
            end
            chk("run_quiet", {done_o, err_o, fios_clear_o}, 0);
        end
        last_i = 1'b0;
        if (drained) begin
            res_push_i = trail;
            cnt       += int'(trail);
            tick();
        end
        res_push_i = 1'b0;
        exp_cnt = (cnt > RES) ? RES : cnt;
        ok      = drained && exp_cnt == RES;
        chk("out_done", done_o, ok ? (1 << w) : 0);
        chk("out_err", err_o, ok ? 0 : (1 << w));
        chk("out_clear", fios_clear_o, !ok);
        chk("out_count", res_count_o, exp_cnt);
        chk("out_grant", grant_o, 1 << w);
        rr_m     = (w + 1) % NR;
        last_cnt = exp_cnt;
        req_i    = req_end;
        tick();
        chk("idle_grant", grant_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_count_hold", res_count_o, last_cnt);
    endtask

    initial begin
        int w, np;
        bit tr;
        logic [NR-1:0] rq, other;
        rst_n = 1'b0; req_i = '0; load_done_i = 1'b0; res_push_i = 1'b0; last_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Request withdrawn while in ARB: back to IDLE with no grant.
        req_i = 2'b01;
        tick();
        chk("arbdrop_busy", busy_o, 1);
        req_i = '0;
        tick();
        chk("arbdrop_idle", busy_o, 0);
        tick();
        chk("arbdrop_grant", grant_o, 0);

        // Single job: 16 pushes with last on the 16th, trailing 17th push.
        job_front(2'b01, 3, w);
        job_back(w, 16, 1, 1, 2'b01, 2'b00);

        // Contention with both requests held.
        for (int j = 0; j < 4; j++) begin
            tr = 1'($urandom);
            job_front(2'b11, 1 + $urandom_range(0, 3), w);
            job_back(w, RES - int'(tr), 1, tr, 2'b11, (j == 3) ? 2'b00 : 2'b11);
        end

        // Short result: 15 blocks in total.
        job_front(2'b01, 2, w);
        job_back(w, 14, 1, 1, 2'b01, 2'b00);

        // Randomized jobs, including over-count (saturating) and short counts.
        for (int j = 0; j < 8; j++) begin
            rq = NR'($urandom_range(1, 3));
            np = $urandom_range(12, 18);
            tr = 1'($urandom);
            job_front(rq, 1 + $urandom_range(0, 4), w);
            job_back(w, np, 1, tr, rq, 2'b00);
        end

        // Watchdog: last never arrives; a normal job follows.
        job_front(2'b10, 2, w);
        job_back(w, 0, 0, 0, 2'b10, 2'b00);
        job_front(2'b10, 1, w);
        job_back(w, 16, 1, 1, 2'b10, 2'b00);

        // Owner drops its request during RUN; the pending one is next.
        job_front(2'b11, 2, w);
        other = NR'(~(1 << w));
        job_back(w, 17, 1, 0, other, other);
        job_front(other, 2, w);
        chk("drop_next_owner", grant_o, other);
        job_back(w, 16, 1, 1, other, 2'b00);

        // Async reset mid-RUN: outputs clear at once, rr_ptr returns to 0.
        job_front(2'b01, 1, w);
        res_push_i = 1'b1;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        res_push_i = 1'b0;
        req_i      = '0;
        #2 rst_n = 1'b1;
        rr_m = 0;
        tick();
        chk("postreset_done_err", {done_o, err_o, busy_o}, 0);
        job_front(2'b10, 2, w);
        chk("postreset_owner", grant_o, 2'b10);
        job_back(w, 17, 1, 0, 2'b10, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
